// File: rtl/led_pwm_if.sv
// Wishbone pipelined bus bundle for led_pwm.
// The master modport drives requests; the slave modport returns responses.
interface led_pwm_if;
  logic [31:0] bus_data_m;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [31:0] bus_data_s;
  logic        bus_ack;
  logic        bus_err;
  logic        bus_stall;

  modport master (
    output bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we,
    input  bus_data_s, bus_ack, bus_err, bus_stall
  );

  modport slave (
    input  bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we,
    output bus_data_s, bus_ack, bus_err, bus_stall
  );
endinterface

// File: rtl/led_pwm.sv
// led_pwm: Wishbone-controlled multi-channel 8-bit LED PWM.
// Registers (word address bits [3:2]): DUTY, PRESCALE, CTRL {invert, enable},
// COUNT (read-only). Define LED_PWM_GAMMA_EN to square-map duty values
// when they are latched into the shadow registers.
module led_pwm #(
  parameter int unsigned LedCount      = 4,
  parameter logic [15:0] PrescaleReset = 16'd0
) (
  input  logic                clk,
  input  logic                reset,
  led_pwm_if.slave            bus,
  output logic [LedCount-1:0] leds
);

  typedef enum logic [1:0] {
    REG_DUTY     = 2'd0,
    REG_PRESCALE = 2'd1,
    REG_CTRL     = 2'd2,
    REG_COUNT    = 2'd3
  } reg_t;

  reg_t                  word;
  logic                  accept;
  logic                  wr;
  logic                  count_wr;
  logic [31:0]           rd_mux;
  logic [8*LedCount-1:0] duty_flat;

  logic [15:0] prescale;
  logic [15:0] pre_cnt;
  logic        enable;
  logic        invert;
  logic [7:0]  pwm_count;
  logic        tick;
  logic        en_rise;
  logic        load_shadow;

  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        resp_live;

  logic unused_bits;
  assign unused_bits = ^{bus.bus_addr[31:4], bus.bus_addr[1:0], bus.bus_data_m};

  assign word     = reg_t'(bus.bus_addr[3:2]);
  assign accept   = bus.bus_cyc && bus.bus_stb;
  assign wr       = accept && bus.bus_we;
  assign count_wr = wr && (word == REG_COUNT);

  assign tick        = enable && (pre_cnt == prescale);
  assign en_rise     = wr && (word == REG_CTRL) && bus.bus_sel[0] && bus.bus_data_m[0] && !enable;
  assign load_shadow = en_rise || (tick && (pwm_count == 8'hFF));

  function automatic logic [7:0] map_duty(input logic [7:0] d);
`ifdef LED_PWM_GAMMA_EN
    logic [15:0] sq;
    sq = {8'd0, d} * {8'd0, d};
    return sq[15:8];
`else
    return d;
`endif
  endfunction

  // Read-data selection from the currently addressed register.
  always_comb begin
    rd_mux = '0;
    unique case (word)
      REG_DUTY:     rd_mux = 32'(duty_flat);
      REG_PRESCALE: rd_mux[15:0] = prescale;
      REG_CTRL:     rd_mux[1:0] = {invert, enable};
      REG_COUNT:    rd_mux[7:0] = pwm_count;
    endcase
  end

  // PRESCALE and CTRL register writes, per byte lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= PrescaleReset;
      enable   <= 1'b0;
      invert   <= 1'b0;
    end else if (wr) begin
      if (word == REG_PRESCALE) begin
        if (bus.bus_sel[0]) prescale[7:0]  <= bus.bus_data_m[7:0];
        if (bus.bus_sel[1]) prescale[15:8] <= bus.bus_data_m[15:8];
      end
      if (word == REG_CTRL && bus.bus_sel[0]) begin
        enable <= bus.bus_data_m[0];
        invert <= bus.bus_data_m[1];
      end
    end
  end

  // Prescaler and PWM counter; a shrinking PRESCALE lets pre_cnt run through FFFF.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pre_cnt   <= '0;
      pwm_count <= '0;
    end else if (tick) begin
      pre_cnt   <= '0;
      pwm_count <= pwm_count + 8'd1;
    end else begin
      pre_cnt   <= pre_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < LedCount; g++) begin : g_led
    logic [7:0] duty;
    logic [7:0] shadow;
    logic       led_q;

    assign duty_flat[8*g +: 8] = duty;
    assign leds[g]             = led_q;

    // DUTY byte lane write for this channel.
    always_ff @(posedge clk) begin
      if (reset) duty <= '0;
      else if (wr && word == REG_DUTY && bus.bus_sel[g]) duty <= bus.bus_data_m[8*g +: 8];
    end

    // Shadow duty latched at period wrap or enable rise (pre-write DUTY value).
    always_ff @(posedge clk) begin
      if (reset) shadow <= '0;
      else if (load_shadow) shadow <= map_duty(duty);
    end

    // Registered PWM compare output.
    always_ff @(posedge clk) begin
      if (reset || !enable) led_q <= 1'b0;
      else led_q <= (pwm_count < shadow) ^ invert;
    end
  end

  // Response pipeline: ack or err one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= accept && !count_wr;
      err_q   <= count_wr;
      rdata_q <= (accept && !bus.bus_we) ? rd_mux : '0;
    end
  end

  // Responses are discarded if the cycle was abandoned or reset arrived.
  assign resp_live      = bus.bus_cyc && !reset;
  assign bus.bus_ack    = ack_q && resp_live;
  assign bus.bus_err    = err_q && resp_live;
  assign bus.bus_data_s = (ack_q && resp_live) ? rdata_q : '0;
  assign bus.bus_stall  = 1'b0;

endmodule
